sar_adc_responder: RTL and testbench
====================================

Name: sar_adc_responder

Overview:
ADC-side responder for the conversion interface driven by the CPU/SA top level. That top level drives CLK_ADC and RSTN_ADC, and reads back ADC[9:0] and ADC_RDY.
This block sequences a 10-bit successive-approximation conversion against an external comparator, one SAR step per CLK_ADC rising edge. It can optionally average 2^AVG_LOG conversions, then presents the code and holds ADC_RDY until the requester releases RSTN_ADC.
It sits between the analog front end (comparator, DAC) and PIPE_CPU_SA_TOP.

Parameters:
CADC_WIDTH, 10, conversion width; also the ADC/DAC_CODE width.
AVG_LOG, 0, log2 of the number of conversions averaged per request (0..4).

Ports:
CLK  input  1  system clock; CLK_ADC is generated synchronously to it.
RST_N  input  1  synchronous active-low reset.
CLK_ADC  input  1  conversion step clock from the requester; each rising edge = one tick.
RSTN_ADC  input  1  requester-side synchronous active-low abort/release.
COMP  input  1  comparator result; 1 when analog input >= DAC_CODE.
DAC_CODE  output  CADC_WIDTH  trial code to the capacitive DAC.
SH  output  1  sample/hold enable; high while in SAMPLE.
BUSY  output  1  high in SAMPLE or CONV.
ADC  output  CADC_WIDTH  final (averaged) code.
ADC_RDY  output  1  result valid; level signal.

Behaviour:
- Tick detection:
  - clk_adc_q registers CLK_ADC; tick = CLK_ADC & ~clk_adc_q.
  - Holding CLK_ADC high yields exactly one tick.
  - clk_adc_q resets to 0, so CLK_ADC already high at reset release counts as one tick.
- RST_N=0 at a CLK edge clears all state: state=IDLE; DAC_CODE, ADC, accumulator and avg counter =0; SH, BUSY, ADC_RDY =0.
- RSTN_ADC=0 has priority over tick in the same cycle:
  - next state = IDLE; DAC_CODE=0, accumulator=0, count=0; SH, BUSY, ADC_RDY =0.
  - ADC retains its last value.
- All outputs are registered.
- FSM, evaluated only on tick while RSTN_ADC=1:
  - IDLE --tick--> SAMPLE: SH=1, BUSY=1, ADC_RDY=0.
  - SAMPLE --tick--> CONV: SH=0; bit index=CADC_WIDTH-1; DAC_CODE=1<<(CADC_WIDTH-1).
  - CONV, per tick:
    - sample COMP; if 0, clear DAC_CODE[idx]; if 1, keep it.
    - if idx>0: set DAC_CODE[idx-1], idx--.
    - if idx==0: the conversion result is the decided DAC_CODE.
  - CONV end of conversion (accumulator width CADC_WIDTH+AVG_LOG, unsigned, no overflow possible):
    - if count < 2^AVG_LOG-1: acc += result, count++, DAC_CODE=0, next=SAMPLE (SH=1).
    - else: ADC = (acc+result)>>AVG_LOG (truncation), ADC_RDY=1, BUSY=0, DAC_CODE=0, next=DONE.
  - DONE: ticks ignored; ADC and ADC_RDY hold until RSTN_ADC=0 → IDLE.
- Ticks in IDLE while RSTN_ADC=0 are ignored. The requester must raise RSTN_ADC before the first tick.
- Latency:
  - AVG_LOG=0: ADC_RDY is visible the CLK cycle after the 12th tick.
  - General case: 1 + 11·2^AVG_LOG ticks.
- Between ticks all state is stable; COMP is sampled only in tick cycles.
- Abort mid-conversion (RSTN_ADC low during SAMPLE or CONV) discards the partial result and accumulator. A new request restarts from IDLE.

Test Plan:
- Ideal comparator COMP=(VIN>=DAC_CODE), VIN=612, AVG_LOG=0, CLK_ADC = CLK/4:
  - → DAC_CODE trial sequence 512, 768, 640, 576, 608, 624, 616, 612, 614, 613.
  - → ADC=612 (10'b1001100100) and ADC_RDY=1 one CLK after tick 12.
  - → BUSY falls in the same cycle ADC_RDY rises.
- Boundaries at AVG_LOG=0: VIN=0 → ADC=0; VIN=1023 → ADC=1023. Both take 12 ticks.
- AVG_LOG=2, VIN per conversion 612, 613, 612, 613:
  - → acc 2450 → ADC=612, ADC_RDY after tick 45.
  - → SH pulses exactly 4 times.
- Handshake: after ADC_RDY, send 5 extra ticks → ADC and ADC_RDY unchanged. Then RSTN_ADC=0 for one cycle → ADC_RDY=0 next cycle, ADC still 612.
- Abort: RSTN_ADC=0 coincident with tick 7 (mid-CONV) → IDLE, DAC_CODE=0, BUSY=0, ADC unchanged. Re-request with VIN=300 → ADC=300.
- Reset: RST_N=0 during DONE → ADC=0, ADC_RDY=0. CLK_ADC held high for 20 cycles → exactly one step (IDLE→SAMPLE).

Source files
------------

// File: rtl/sar_adc_responder_if.sv
// Conversion-side bundle of the SAR ADC responder: requester handshake
// (CLK_ADC, RSTN_ADC, ADC, ADC_RDY) plus the analog front-end hooks
// (COMP, DAC_CODE, SH, BUSY).
interface sar_adc_responder_if #(
   parameter int CADC_WIDTH = 10
);
   logic                  CLK_ADC;
   logic                  RSTN_ADC;
   logic                  COMP;
   logic [CADC_WIDTH-1:0] DAC_CODE;
   logic                  SH;
   logic                  BUSY;
   logic [CADC_WIDTH-1:0] ADC;
   logic                  ADC_RDY;

   // The responder consumes the step clock, release and comparator result
   modport slave (
      input  CLK_ADC, RSTN_ADC, COMP,
      output DAC_CODE, SH, BUSY, ADC, ADC_RDY
   );

   // The requester / front-end side drives the opposite directions
   modport master (
      output CLK_ADC, RSTN_ADC, COMP,
      input  DAC_CODE, SH, BUSY, ADC, ADC_RDY
   );
endinterface

// File: rtl/sar_adc_responder.sv
// SAR ADC responder: one successive-approximation step per rising edge of
// CLK_ADC (sampled in the CLK domain), optional averaging of 2^AVG_LOG
// conversions, result held on ADC with ADC_RDY until the requester drops
// RSTN_ADC.
module sar_adc_responder #(
   parameter int CADC_WIDTH = 10,
   parameter int AVG_LOG    = 0
) (
   input  logic               CLK,
   input  logic               RST_N,
   sar_adc_responder_if.slave link
);

   localparam int IDX_W = (CADC_WIDTH > 1) ? $clog2(CADC_WIDTH) : 1;
   localparam int ACC_W = CADC_WIDTH + AVG_LOG;
   localparam int CNT_W = AVG_LOG + 1;

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((1 << AVG_LOG) - 1);
   localparam logic [CADC_WIDTH-1:0] MSB_CODE = {1'b1, {(CADC_WIDTH-1){1'b0}}};
   localparam logic [IDX_W-1:0]      IDX_TOP  = IDX_W'(CADC_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      CONV,
      DONE
   } state_t;

   state_t                  state;
   logic                    clk_adc_q;
   logic [IDX_W-1:0]        bit_idx;
   logic [ACC_W-1:0]        acc;
   logic [CNT_W-1:0]        avg_cnt;

   logic                    tick;
   logic [CADC_WIDTH-1:0]   decided;
   logic [CADC_WIDTH-1:0]   next_bit;
   logic [ACC_W-1:0]        acc_sum;
   logic [CADC_WIDTH-1:0]   avg_code;

   assign tick = link.CLK_ADC & ~clk_adc_q;

   // Resolve the current trial bit from COMP and prepare the next trial bit and averaged result
   always_comb begin
      decided  = link.DAC_CODE;
      next_bit = '0;
      if (!link.COMP) begin
         decided[bit_idx] = 1'b0;
      end
      if (bit_idx != '0) begin
         next_bit[bit_idx - IDX_W'(1)] = 1'b1;
      end
      acc_sum  = acc + ACC_W'(decided);
      avg_code = CADC_WIDTH'(acc_sum >> AVG_LOG);
   end

   // Conversion sequencer: requester release beats a step, and steps only advance on a CLK_ADC rising edge
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state         <= IDLE;
         clk_adc_q     <= 1'b0;
         bit_idx       <= '0;
         acc           <= '0;
         avg_cnt       <= '0;
         link.DAC_CODE <= '0;
         link.ADC      <= '0;
         link.SH       <= 1'b0;
         link.BUSY     <= 1'b0;
         link.ADC_RDY  <= 1'b0;
      end else begin
         clk_adc_q <= link.CLK_ADC;
         if (!link.RSTN_ADC) begin
            state         <= IDLE;
            bit_idx       <= '0;
            acc           <= '0;
            avg_cnt       <= '0;
            link.DAC_CODE <= '0;
            link.SH       <= 1'b0;
            link.BUSY     <= 1'b0;
            link.ADC_RDY  <= 1'b0;
         end else if (tick) begin
            unique case (state)
               IDLE: begin
                  state        <= SAMPLE;
                  link.SH      <= 1'b1;
                  link.BUSY    <= 1'b1;
                  link.ADC_RDY <= 1'b0;
               end
               SAMPLE: begin
                  state         <= CONV;
                  link.SH       <= 1'b0;
                  bit_idx       <= IDX_TOP;
                  link.DAC_CODE <= MSB_CODE;
               end
               CONV: begin
                  if (bit_idx != '0) begin
                     link.DAC_CODE <= decided | next_bit;
                     bit_idx       <= bit_idx - IDX_W'(1);
                  end else if (avg_cnt < CNT_LAST) begin
                     acc           <= acc_sum;
                     avg_cnt       <= avg_cnt + CNT_W'(1);
                     link.DAC_CODE <= '0;
                     link.SH       <= 1'b1;
                     state         <= SAMPLE;
                  end else begin
                     link.ADC      <= avg_code;
                     link.ADC_RDY  <= 1'b1;
                     link.BUSY     <= 1'b0;
                     link.DAC_CODE <= '0;
                     acc           <= '0;
                     avg_cnt       <= '0;
                     state         <= DONE;
                  end
               end
               DONE: begin
                  state <= DONE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sar_adc_responder.sv
// Bench for sar_adc_responder: one instance without averaging, one with
// four-way averaging, both driven by an ideal comparator. Expected codes and
// tick latencies go into queues; monitors pop them when ADC_RDY rises.
module tb_sar_adc_responder;

   localparam int W = 10;

   typedef struct {
      int code;
      int lat;
   } exp_t;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   int vin0 = 0;
   int vin2 = 0;
   int tick_cnt0 = 0;
   int tick_cnt2 = 0;
   int sh_cnt2 = 0;
   int total = 0;
   int bad = 0;
   bit rdy0_prev = 1'b0;
   bit rdy2_prev = 1'b0;
   bit sh2_prev = 1'b0;
   exp_t exp0[$];
   exp_t exp2[$];

   sar_adc_responder_if #(.CADC_WIDTH(W)) bus0 ();
   sar_adc_responder_if #(.CADC_WIDTH(W)) bus2 ();

   sar_adc_responder #(.CADC_WIDTH(W), .AVG_LOG(0)) dut0 (
      .CLK  (CLK),
      .RST_N(RST_N),
      .link (bus0.slave)
   );

   sar_adc_responder #(.CADC_WIDTH(W), .AVG_LOG(2)) dut2 (
      .CLK  (CLK),
      .RST_N(RST_N),
      .link (bus2.slave)
   );

   // Ideal comparators: analog input at or above the DAC trial code
   assign bus0.COMP = (vin0 >= int'(bus0.DAC_CODE));
   assign bus2.COMP = (vin2 >= int'(bus2.DAC_CODE));

   // Free-running system clock
   always #5 CLK = ~CLK;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Binary-search trial code presented at a given step for an ideal comparator
   function automatic int trial_at(input int vin, input int step);
      int code = 0;
      for (int b = W - 1; b >= 0; b--) begin
         int t = code | (1 << b);
         if ((W - 1 - b) == step) return t;
         if (vin >= t) code = t;
      end
      return 0;
   endfunction

   // One CLK_ADC period (2 CLK high, 2 CLK low); optional abort coincident with the rising edge
   task automatic tick_adc(input int which, input bit abort);
      if (which == 0) begin
         bus0.CLK_ADC = 1'b1;
         if (abort) bus0.RSTN_ADC = 1'b0;
         tick_cnt0++;
      end else begin
         bus2.CLK_ADC = 1'b1;
         if (abort) bus2.RSTN_ADC = 1'b0;
         tick_cnt2++;
      end
      @(negedge CLK);
      bus0.RSTN_ADC = 1'b1;
      bus2.RSTN_ADC = 1'b1;
      @(negedge CLK);
      if (which == 0) bus0.CLK_ADC = 1'b0;
      else            bus2.CLK_ADC = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   // Requester release: RSTN_ADC low for one CLK cycle
   task automatic release_req(input int which);
      if (which == 0) bus0.RSTN_ADC = 1'b0;
      else            bus2.RSTN_ADC = 1'b0;
      @(negedge CLK);
      bus0.RSTN_ADC = 1'b1;
      bus2.RSTN_ADC = 1'b1;
      @(negedge CLK);
   endtask

   // Single conversion on the non-averaging instance with a constant input
   task automatic applyStimulus0(input int vin, input bit check_trials);
      exp_t e;
      vin0      = vin;
      tick_cnt0 = 0;
      e.code    = (vin > 1023) ? 1023 : vin;
      e.lat     = 12;
      exp0.push_back(e);
      for (int k = 1; k <= 12; k++) begin
         tick_adc(0, 1'b0);
         if (check_trials && k == 1) begin
            checkOutput("dut0_sample_sh", int'(bus0.SH), 1);
            checkOutput("dut0_sample_busy", int'(bus0.BUSY), 1);
         end
         if (check_trials && k >= 2 && k <= 11)
            checkOutput($sformatf("dut0_trial%0d", k - 2), int'(bus0.DAC_CODE), trial_at(vin, k - 2));
      end
      checkOutput("dut0_rdy_seen", exp0.size(), 0);
      checkOutput("dut0_dac_idle", int'(bus0.DAC_CODE), 0);
   endtask

   // Four averaged conversions, each with its own input level
   task automatic applyStimulus2(input int v0, input int v1, input int v2, input int v3);
      int   vins [4];
      exp_t e;
      vins[0]   = v0;
      vins[1]   = v1;
      vins[2]   = v2;
      vins[3]   = v3;
      tick_cnt2 = 0;
      sh_cnt2   = 0;
      e.code    = (v0 + v1 + v2 + v3) / 4;
      e.lat     = 1 + 11 * 4;
      exp2.push_back(e);
      for (int t = 1; t <= 45; t++) begin
         if (t >= 2 && ((t - 2) % 11) == 0) vin2 = vins[(t - 2) / 11];
         tick_adc(2, 1'b0);
      end
      checkOutput("dut2_rdy_seen", exp2.size(), 0);
   endtask

   // Scoreboard monitor for the non-averaging instance
   always @(negedge CLK) begin
      exp_t e;
      if (bus0.ADC_RDY && !rdy0_prev) begin
         if (exp0.size() == 0) begin
            checkOutput("dut0_spurious_rdy", 1, 0);
         end else begin
            e = exp0.pop_front();
            checkOutput("dut0_adc", int'(bus0.ADC), e.code);
            checkOutput("dut0_latency", tick_cnt0, e.lat);
            checkOutput("dut0_busy_fall", int'(bus0.BUSY), 0);
         end
      end
      rdy0_prev = bus0.ADC_RDY;
   end

   // Scoreboard monitor for the averaging instance, also counting SH pulses
   always @(negedge CLK) begin
      exp_t e;
      if (bus2.SH && !sh2_prev) sh_cnt2++;
      sh2_prev = bus2.SH;
      if (bus2.ADC_RDY && !rdy2_prev) begin
         if (exp2.size() == 0) begin
            checkOutput("dut2_spurious_rdy", 1, 0);
         end else begin
            e = exp2.pop_front();
            checkOutput("dut2_adc", int'(bus2.ADC), e.code);
            checkOutput("dut2_latency", tick_cnt2, e.lat);
            checkOutput("dut2_sh_pulses", sh_cnt2, 4);
            checkOutput("dut2_busy_fall", int'(bus2.BUSY), 0);
         end
      end
      rdy2_prev = bus2.ADC_RDY;
   end

   // Main stimulus sequence
   initial begin
      int v;
      bus0.CLK_ADC  = 1'b0;
      bus0.RSTN_ADC = 1'b1;
      bus2.CLK_ADC  = 1'b0;
      bus2.RSTN_ADC = 1'b1;
      @(negedge CLK);
      repeat (3) @(negedge CLK);

      checkOutput("reset_adc", int'(bus0.ADC), 0);
      checkOutput("reset_rdy", int'(bus0.ADC_RDY), 0);
      checkOutput("reset_busy", int'(bus0.BUSY), 0);
      checkOutput("reset_sh", int'(bus0.SH), 0);
      checkOutput("reset_dac", int'(bus0.DAC_CODE), 0);
      checkOutput("reset_adc2", int'(bus2.ADC), 0);
      RST_N = 1'b1;
      @(negedge CLK);

      $display("[TB] nominal conversion VIN=612");
      applyStimulus0(612, 1'b1);

      $display("[TB] extra ticks while done, then release");
      repeat (5) tick_adc(0, 1'b0);
      checkOutput("hold_adc", int'(bus0.ADC), 612);
      checkOutput("hold_rdy", int'(bus0.ADC_RDY), 1);
      bus0.RSTN_ADC = 1'b0;
      @(negedge CLK);
      bus0.RSTN_ADC = 1'b1;
      checkOutput("release_rdy", int'(bus0.ADC_RDY), 0);
      checkOutput("release_adc", int'(bus0.ADC), 612);
      @(negedge CLK);

      $display("[TB] boundary inputs");
      applyStimulus0(0, 1'b1);
      release_req(0);
      applyStimulus0(1023, 1'b1);
      release_req(0);

      $display("[TB] abort mid-conversion");
      vin0      = 500;
      tick_cnt0 = 0;
      for (int k = 1; k <= 6; k++) tick_adc(0, 1'b0);
      tick_adc(0, 1'b1);
      checkOutput("abort_dac", int'(bus0.DAC_CODE), 0);
      checkOutput("abort_busy", int'(bus0.BUSY), 0);
      checkOutput("abort_sh", int'(bus0.SH), 0);
      checkOutput("abort_rdy", int'(bus0.ADC_RDY), 0);
      checkOutput("abort_adc", int'(bus0.ADC), 1023);
      applyStimulus0(300, 1'b0);
      release_req(0);

      $display("[TB] random conversions");
      for (int i = 0; i < 4; i++) begin
         v = int'($urandom_range(1023, 0));
         applyStimulus0(v, 1'b1);
         release_req(0);
      end

      $display("[TB] averaged conversions");
      applyStimulus2(612, 613, 612, 613);
      release_req(2);
      applyStimulus2(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                     int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)));

      $display("[TB] reset while done, CLK_ADC held high");
      applyStimulus0(612, 1'b0);
      RST_N = 1'b0;
      @(negedge CLK);
      checkOutput("rst_done_adc", int'(bus0.ADC), 0);
      checkOutput("rst_done_rdy", int'(bus0.ADC_RDY), 0);
      checkOutput("rst_done_adc2", int'(bus2.ADC), 0);
      bus0.CLK_ADC = 1'b1;
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);
      checkOutput("held_sh", int'(bus0.SH), 1);
      checkOutput("held_busy", int'(bus0.BUSY), 1);
      checkOutput("held_dac", int'(bus0.DAC_CODE), 0);
      bus0.CLK_ADC = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      vin0 = 612;
      tick_adc(0, 1'b0);
      checkOutput("held_next_dac", int'(bus0.DAC_CODE), 512);
      checkOutput("held_next_sh", int'(bus0.SH), 0);

      repeat (4) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
